accum_avalon_slave: RTL and testbench

Avalon-MM slave that the Nios II CPU reads and writes through the SoC bus to control the board-side accumulate hardware. It synchronizes and debounces the run/accumulate push-button, samples the switches, and holds an 8-bit accumulator that drives the LEDs. On each debounced press it can either accumulate the switch value in fabric or post an event and interrupt for software. It sits between the SoC interconnect and the KEY/SW/LEDR pins.

---
 rtl/accum_avalon_slave.sv | 162 ++++++++++++++++
 tb/tb_accum_avalon_slave.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_avalon_slave.sv
// Avalon-MM accumulator slave: key debounce, switch sampling, 8-bit LED accumulator.
// Optional macro ACCUM_SAT_EN: hardware adds saturate at 0xFF instead of wrapping.
module accum_avalon_slave #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  input  logic        key_n,
  input  logic [9:0]  sw,
  output logic [7:0]  led
);

  localparam int DB = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CW = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB - 1);

  localparam logic [1:0] A_ACC  = 2'd0;
  localparam logic [1:0] A_SW   = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  logic          key_s1;
  logic          key_s2;
  logic [9:0]    sw_s1;
  logic [9:0]    sw_s2;
  logic [CW-1:0] db_cnt;
  logic          key_stable;
  logic [7:0]    acc;
  logic          st_press;
  logic          st_ovf;
  logic          irq_en;
  logic          hw_acc;

  logic          key_diff;
  logic          key_flip;
  logic          press_evt;
  logic          wr_acc;
  logic          wr_stat;
  logic          wr_ctrl;
  logic          hw_add;
  logic [8:0]    sum;
  logic [7:0]    add_val;
  logic          add_carry;
  logic [31:0]   rd_mux;
  logic          unused_wd;

  assign unused_wd = ^avs_writedata[31:8];

  assign key_diff  = key_s2 != key_stable;
  assign key_flip  = key_diff && (db_cnt == CNT_MAX);
  assign press_evt = key_flip && key_stable;

  assign wr_acc  = avs_write && (avs_address == A_ACC);
  assign wr_stat = avs_write && (avs_address == A_STAT);
  assign wr_ctrl = avs_write && (avs_address == A_CTRL);

  assign sum       = {1'b0, acc} + {1'b0, sw_s2[7:0]};
  assign add_carry = sum[8];
  assign hw_add    = press_evt && hw_acc;

`ifdef ACCUM_SAT_EN
  assign add_val = add_carry ? 8'hFF : sum[7:0];
`else
  assign add_val = sum[7:0];
`endif

  // Two-flop synchronizers for the asynchronous key and switches
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce: accept a level only after DB consecutive differing cycles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db_cnt     <= '0;
      key_stable <= 1'b1;
    end else if (!key_diff) begin
      db_cnt <= '0;
    end else if (key_flip) begin
      db_cnt     <= '0;
      key_stable <= ~key_stable;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Accumulator: CPU write has priority over a hardware add
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (wr_acc) begin
      acc <= avs_writedata[7:0];
    end else if (hw_add) begin
      acc <= add_val;
    end
  end

  // Sticky status bits: a same-cycle set beats the W1C clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_press <= 1'b0;
      st_ovf   <= 1'b0;
    end else begin
      st_press <= (st_press & ~(wr_stat & avs_writedata[0]))
                | press_evt;
      st_ovf   <= (st_ovf & ~(wr_stat & avs_writedata[1]))
                | (hw_add & add_carry & ~wr_acc);
    end
  end

  // Control register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      hw_acc <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en <= avs_writedata[0];
      hw_acc <= avs_writedata[1];
    end
  end

  // Read mux over pre-update register values
  always_comb begin
    rd_mux = '0;
    unique case (avs_address)
      A_ACC:  rd_mux[7:0] = acc;
      A_SW:   rd_mux[9:0] = sw_s2;
      A_STAT: rd_mux[1:0] = {st_ovf, st_press};
      A_CTRL: rd_mux[1:0] = {hw_acc, irq_en};
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

  assign led = acc;
  assign irq = irq_en & st_press;

endmodule

// File: tb/tb_accum_avalon_slave.sv
// Directed bench for accum_avalon_slave with DEBOUNCE_CYCLES=4.
// Expected values are hand-derived from the register and timing rules.
module tb_accum_avalon_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic        key_n;
  logic [9:0]  sw;
  logic [7:0]  led;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accum_avalon_slave #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .irq(irq),
    .key_n(key_n),
    .sw(sw),
    .led(led)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    tick();
    d = avs_readdata;
  endtask

  task automatic release_key();
    key_n = 1'b1;
    tick(8);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    key_n   = 1'b0;
    sw      = 10'h3FF;
    tick(3);
    n_cmp++;
    if (led !== 8'h00) begin
      n_err++;
      $display("FAIL reset_led got=%h exp=00", led);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    n_cmp++;
    if (avs_readdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata got=%h exp=0", avs_readdata);
    end
    key_n   = 1'b1;
    sw      = 10'h000;
    reset_n = 1'b1;
    tick(3);
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL reset_acc got=%h exp=0", d);
    end
    bus_read(2'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL reset_status got=%h exp=0", d);
    end
    bus_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL reset_ctrl got=%h exp=0", d);
    end
  endtask

  task automatic test_press();
    logic [31:0] d;
    bus_write(2'd3, 32'h2);
    sw = 10'h005;
    tick(3);
    key_n = 1'b0;
    tick();
    tick(4);
    n_cmp++;
    if (led !== 8'h00) begin
      n_err++;
      $display("FAIL press_early got=%h exp=00", led);
    end
    tick();
    n_cmp++;
    if (led !== 8'h05) begin
      n_err++;
      $display("FAIL press_first got=%h exp=05", led);
    end
    release_key();
    n_cmp++;
    if (led !== 8'h05) begin
      n_err++;
      $display("FAIL press_release got=%h exp=05", led);
    end
    key_n = 1'b0;
    tick(6);
    n_cmp++;
    if (led !== 8'h0A) begin
      n_err++;
      $display("FAIL press_second got=%h exp=0a", led);
    end
    release_key();
    bus_read(2'd2, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++;
      $display("FAIL press_status got=%h exp=1", d);
    end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0A) begin
      n_err++;
      $display("FAIL press_acc_rd got=%h exp=0a", d);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    bus_write(2'd2, 32'h1);
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(10);
    bus_read(2'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL glitch_status got=%h exp=0", d);
    end
    n_cmp++;
    if (led !== 8'h0A) begin
      n_err++;
      $display("FAIL glitch_acc got=%h exp=0a", led);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  exp_acc;
`ifdef ACCUM_SAT_EN
    exp_acc = 8'hFF;
`else
    exp_acc = 8'h01;
`endif
    bus_write(2'd0, 32'hFE);
    n_cmp++;
    if (led !== 8'hFE) begin
      n_err++;
      $display("FAIL ovf_load got=%h exp=fe", led);
    end
    sw = 10'h003;
    tick(3);
    key_n = 1'b0;
    tick(6);
    release_key();
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== {24'h0, exp_acc}) begin
      n_err++;
      $display("FAIL ovf_acc got=%h exp=%h", d, exp_acc);
    end
    bus_read(2'd2, d);
    n_cmp++;
    if (d !== 32'h3) begin
      n_err++;
      $display("FAIL ovf_status got=%h exp=3", d);
    end
    bus_write(2'd2, 32'h3);
    bus_read(2'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL ovf_clear got=%h exp=0", d);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic [7:0]  acc0;
    acc0 = led;
    bus_write(2'd3, 32'h1);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_idle got=%b exp=0", irq);
    end
    key_n = 1'b0;
    tick(5);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_early got=%b exp=0", irq);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_rise got=%b exp=1", irq);
    end
    n_cmp++;
    if (led !== acc0) begin
      n_err++;
      $display("FAIL irq_acc got=%h exp=%h", led, acc0);
    end
    release_key();
    bus_write(2'd2, 32'h1);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear got=%b exp=0", irq);
    end
    key_n = 1'b0;
    tick(5);
    avs_address   = 2'd2;
    avs_writedata = 32'h1;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
    bus_read(2'd2, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++;
      $display("FAIL irq_w1c_race got=%h exp=1", d);
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_held got=%b exp=1", irq);
    end
    release_key();
    bus_write(2'd2, 32'h3);
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus_write(2'd3, 32'h2);
    sw = 10'h010;
    tick(3);
    key_n = 1'b0;
    tick(5);
    avs_address   = 2'd0;
    avs_writedata = 32'h40;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
    n_cmp++;
    if (led !== 8'h40) begin
      n_err++;
      $display("FAIL coll_acc got=%h exp=40", led);
    end
    release_key();
    bus_read(2'd2, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++;
      $display("FAIL coll_status got=%h exp=1", d);
    end
    bus_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h2) begin
      n_err++;
      $display("FAIL coll_ctrl got=%h exp=2", d);
    end
  endtask

  task automatic test_sw_latency();
    logic [31:0] d;
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h010) begin
      n_err++;
      $display("FAIL sw_base got=%h exp=010", d);
    end
    sw = 10'h155;
    tick();
    avs_address = 2'd1;
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    tick();
    n_cmp++;
    if (avs_readdata !== 32'h010) begin
      n_err++;
      $display("FAIL sw_lag got=%h exp=010", avs_readdata);
    end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h155) begin
      n_err++;
      $display("FAIL sw_new got=%h exp=155", d);
    end
    tick(3);
    n_cmp++;
    if (avs_readdata !== 32'h155) begin
      n_err++;
      $display("FAIL rd_hold got=%h exp=155", avs_readdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    key_n = 1'b0;
    tick(4);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_cmp++;
    if (led !== 8'h00) begin
      n_err++;
      $display("FAIL rst_mid_led got=%h exp=00", led);
    end
    tick(4);
    bus_read(2'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_redebounce got=%h exp=0", d);
    end
    bus_read(2'd2, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++;
      $display("FAIL rst_mid_press got=%h exp=1", d);
    end
    release_key();
  endtask

  initial begin
    reset_n       = 1'b0;
    avs_address   = 2'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = 32'h0;
    key_n         = 1'b1;
    sw            = 10'h000;
    test_reset();
    test_press();
    test_glitch();
    test_overflow();
    test_irq();
    test_collision();
    test_sw_latency();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
